// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-RAM bus master.
// Size codes, FSM states and the alignment rule live here.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    // Reserved size (11) is reported the same way as a misaligned access.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] boff);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = boff[0];
            SZ_WORD: misaligned = |boff;
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for the data RAM: load extract/extend
// and sub-word store merge into a sampled word.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  boff,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mword
);

    logic [4:0]  sh;
    logic [31:0] mask;
    logic [15:0] lane;

    always_comb begin
        sh   = 5'd0;
        mask = 32'hFFFF_FFFF;
        case (size)
            SZ_BYTE: begin
                sh   = BIG_ENDIAN ? {~boff, 3'b000}
                                  : {boff, 3'b000};
                mask = 32'h0000_00FF << sh;
            end
            SZ_HALF: begin
                sh   = BIG_ENDIAN ? {~boff[1], 4'b0000}
                                  : {boff[1], 4'b0000};
                mask = 32'h0000_FFFF << sh;
            end
            default: ;
        endcase

        lane  = 16'(rword >> sh);
        ldata = rword;
        case (size)
            SZ_BYTE: ldata = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
            SZ_HALF: ldata = {{16{~is_unsigned & lane[15]}}, lane};
            default: ;
        endcase

        // Untouched lanes keep the value read back in RMW_RD.
        mword = (rword & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/dmem_bus_master.sv
// MEM-stage initiator for the shared data-RAM bus; sub-word
// stores become a read-modify-write pair of bus cycles.
module dmem_bus_master
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] Addr,
    inout  wire  [31:0]       Data,
    output logic              R_W,
    output logic              CS
);

    state_t      state;
    logic [1:0]  size_q;
    logic [1:0]  boff_q;
    logic        uns_q;
    logic [31:0] wbuf;
    logic [31:0] ldata;
    logic [31:0] mword;

    assign req_ready = (state == IDLE);
    assign Data      = R_W ? wbuf : {32{1'bz}};

    mem_lane_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_align (
        .boff       (boff_q),
        .size       (size_q),
        .is_unsigned(uns_q),
        .rword      (Data),
        .wdata      (wbuf),
        .ldata      (ldata),
        .mword      (mword)
    );

    // Bus strobes are flops so nothing from req_* reaches the RAM pins.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            CS         <= 1'b0;
            R_W        <= 1'b0;
            Addr       <= '0;
            size_q     <= SZ_BYTE;
            boff_q     <= 2'b00;
            uns_q      <= 1'b0;
            wbuf       <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: if (req_valid) begin
                    Addr       <= req_addr[ADDR_W+1:2];
                    size_q     <= req_size;
                    boff_q     <= req_addr[1:0];
                    uns_q      <= req_unsigned;
                    wbuf       <= req_wdata;
                    resp_rdata <= '0;
                    resp_err   <= misaligned(req_size, req_addr[1:0]);
                    if (misaligned(req_size, req_addr[1:0])) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (!req_we) begin
                        CS    <= 1'b1;
                        state <= RD;
                    end else if (req_size == SZ_WORD) begin
                        CS    <= 1'b1;
                        R_W   <= 1'b1;
                        state <= WR;
                    end else begin
                        CS    <= 1'b1;
                        state <= RMW_RD;
                    end
                end
                RD: begin
                    resp_rdata <= ldata;
                    CS         <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_RD: begin
                    wbuf  <= mword;
                    R_W   <= 1'b1;
                    state <= WR;
                end
                WR: begin
                    CS         <= 1'b0;
                    R_W        <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_master.sv
// Bench for dmem_bus_master: bus RAM, transaction-level model,
// per-cycle compare process, directed and random requests.
module tb_dmem_bus_master;

    localparam int AW = 12;
    localparam bit BE = 1'b1;
    localparam int NW = 1 << AW;

    logic          CLK;
    logic          Rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] Addr;
    wire  [31:0]   Data;
    logic          R_W;
    logic          CS;

    logic [31:0] ram  [NW];
    logic [31:0] mram [NW];
    bit          ram_init;
    bit          m_init;
    bit          cmp_on;
    int          checks;
    int          errors;

    dmem_bus_master #(
        .ADDR_W(AW),
        .BIG_ENDIAN(BE)
    ) dut (
        .CLK         (CLK),
        .Rst         (Rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .Addr        (Addr),
        .Data        (Data),
        .R_W         (R_W),
        .CS          (CS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] initw(input int i);
        if (i == 5) return 32'h8899_AABB;
        if (i == 9) return 32'h0BAD_F00D;
        return (i * 32'h0100_0193) ^ 32'h5A5A_5A5A;
    endfunction

    // RAM: reads while selected for read, writes on the negedge.
    assign Data = (CS && !R_W) ? ram[Addr] : {32{1'bz}};

    always @(negedge CLK or posedge Rst) begin
        if (Rst) begin
            if (!ram_init) begin
                for (int i = 0; i < NW; i++) ram[i] <= initw(i);
                ram_init <= 1'b1;
            end
        end else if (CS && R_W) begin
            ram[Addr] <= Data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Byte i of a word in memory order.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        return BE ? w[8*(3-i) +: 8] : w[8*i +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input int i,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        if (BE) r[8*(3-i) +: 8] = b;
        else    r[8*i +: 8] = b;
        return r;
    endfunction

    function automatic logic bad(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w,
        input logic [1:0] sz, input logic un, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        int          k;
        k = 2 * a[1];
        if (sz == 2'd0) begin
            b = byte_of(w, a);
            return un ? {24'd0, b} : {{24{b[7]}}, b};
        end
        if (sz == 2'd1) begin
            h = BE ? {byte_of(w, k), byte_of(w, k + 1)}
                   : {byte_of(w, k + 1), byte_of(w, k)};
            return un ? {16'd0, h} : {{16{h[15]}}, h};
        end
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w,
        input logic [1:0] sz, input logic [1:0] a, input logic [31:0] wd);
        int k;
        k = 2 * a[1];
        if (sz == 2'd0) return put_byte(w, a, wd[7:0]);
        if (sz == 2'd1) begin
            if (BE) return put_byte(put_byte(w, k, wd[15:8]), k + 1, wd[7:0]);
            return put_byte(put_byte(w, k, wd[7:0]), k + 1, wd[15:8]);
        end
        return wd;
    endfunction

    // Transaction model: m_k counts cycles since accept,
    // m_lat is the cycle the response appears in.
    logic          m_busy;
    logic          m_we;
    logic          m_err;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wword;
    logic [31:0]   m_rdata;
    int            m_k;
    int            m_lat;

    always @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            m_busy <= 1'b0;
            m_addr <= '0;
            if (!m_init) begin
                for (int i = 0; i < NW; i++) mram[i] <= initw(i);
                m_init <= 1'b1;
            end
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy  <= 1'b1;
                m_k     <= 1;
                m_addr  <= req_addr[AW+1:2];
                m_we    <= req_we;
                m_err   <= bad(req_size, req_addr[1:0]);
                m_lat   <= bad(req_size, req_addr[1:0]) ? 1 :
                           (req_we && req_size != 2'd2) ? 3 : 2;
                m_rdata <= (bad(req_size, req_addr[1:0]) || req_we) ? 32'd0 :
                           model_load(mram[req_addr[AW+1:2]], req_size,
                                      req_unsigned, req_addr[1:0]);
                m_wword <= model_store(mram[req_addr[AW+1:2]], req_size,
                                       req_addr[1:0], req_wdata);
            end
        end else if (m_k < m_lat) begin
            if (m_we && m_k == m_lat - 1) mram[m_addr] <= m_wword;
            m_k <= m_k + 1;
        end else if (resp_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(posedge CLK) begin
        #4;
        if (cmp_on && !Rst) begin
            chk("req_ready", req_ready, !m_busy);
            chk("CS", CS, m_busy && m_k < m_lat);
            chk("R_W", R_W, m_busy && m_we && m_k == m_lat - 1);
            chk("Addr", Addr, m_addr);
            chk("resp_valid", resp_valid, m_busy && m_k >= m_lat);
            if (m_busy && m_k >= m_lat) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", resp_err, m_err);
            end
            if (R_W) chk("Data", Data, m_wword);
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic un,
        input logic [AW+1:0] a, input logic [31:0] wd, input int hold,
        input bit junk, output logic [31:0] rd, output logic er,
        output int lat, output int vcyc, output bit cs_seen);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge CLK); #2; n++;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = a;
        req_wdata    = wd;
        resp_ready   = (hold == 0);
        @(posedge CLK); #2;
        req_valid = 1'b0;
        lat       = 1;
        cs_seen   = CS;
        while (!resp_valid && lat < 10) begin
            if (junk) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we    = 1'($urandom_range(0, 1));
                req_size  = 2'($urandom_range(0, 3));
                req_addr  = AW'(0) + (AW+2)'($urandom);
                req_wdata = $urandom;
            end
            @(posedge CLK); #2;
            lat++;
            cs_seen |= CS;
        end
        req_valid = 1'b0;
        chk("resp_arrives", resp_valid, 1'b1);
        rd   = resp_rdata;
        er   = resp_err;
        vcyc = 0;
        while (resp_valid && vcyc < hold + 5) begin
            vcyc++;
            if (vcyc > hold) resp_ready = 1'b1;
            @(posedge CLK); #2;
        end
        resp_ready = 1'b1;
    endtask

    logic [31:0]   rd;
    logic          er;
    int            lat;
    int            vc;
    bit            cs_seen;
    logic [AW-1:0] wsel;
    logic [AW+1:0] ra;

    initial begin
        Rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b1;
        #1 Rst = 1'b1;
        #3;
        chk("rst_CS", CS, 1'b0);
        chk("rst_R_W", R_W, 1'b0);
        chk("rst_Addr", Addr, 32'd0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_req_ready", req_ready, 1'b1);
        repeat (2) @(posedge CLK);
        #2 Rst = 1'b0;
        cmp_on = 1'b1;

        do_req(1'b0, 2'd2, 1'b0, 14'h0014, 32'd0, 0, 1'b0, rd, er, lat, vc, cs_seen);
        chk("lw_rdata", rd, 32'h8899_AABB);
        chk("lw_err", er, 1'b0);
        chk("lw_lat", lat, 2);
        chk("lw_cs", cs_seen, 1'b1);
        do_req(1'b0, 2'd0, 1'b0, 14'h0015, 32'd0, 0, 1'b0, rd, er, lat, vc, cs_seen);
        chk("lb_rdata", rd, 32'hFFFF_FF99);
        do_req(1'b0, 2'd0, 1'b1, 14'h0015, 32'd0, 0, 1'b0, rd, er, lat, vc, cs_seen);
        chk("lbu_rdata", rd, 32'h0000_0099);
        do_req(1'b0, 2'd1, 1'b0, 14'h0016, 32'd0, 0, 1'b0, rd, er, lat, vc, cs_seen);
        chk("lh_rdata", rd, 32'hFFFF_AABB);
        chk("lh_lat", lat, 2);

        do_req(1'b1, 2'd0, 1'b0, 14'h0016, 32'h0000_00CC, 0, 1'b0, rd, er, lat, vc, cs_seen);
        chk("sb_lat", lat, 3);
        chk("sb_rdata", rd, 32'd0);
        chk("sb_ram5", ram[5], 32'h8899_CCBB);

        do_req(1'b1, 2'd2, 1'b0, 14'h0020, 32'h1234_5678, 4, 1'b0, rd, er, lat, vc, cs_seen);
        chk("sw_lat", lat, 2);
        chk("sw_hold", vc, 5);
        chk("sw_ram8", ram[8], 32'h1234_5678);

        do_req(1'b0, 2'd2, 1'b0, 14'h0022, 32'd0, 0, 1'b0, rd, er, lat, vc, cs_seen);
        chk("mis_err", er, 1'b1);
        chk("mis_rdata", rd, 32'd0);
        chk("mis_lat", lat, 1);
        chk("mis_cs", cs_seen, 1'b0);
        do_req(1'b1, 2'd3, 1'b0, 14'h0010, 32'hFFFF_FFFF, 0, 1'b0, rd, er, lat, vc, cs_seen);
        chk("rsv_err", er, 1'b1);
        chk("rsv_lat", lat, 1);
        chk("rsv_cs", cs_seen, 1'b0);

        // Reset in the read half of a halfword store.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd1;
        req_addr  = 14'h0024;
        req_wdata = 32'h0000_BEEF;
        @(posedge CLK); #2;
        req_valid = 1'b0;
        chk("rstmid_cs_before", CS, 1'b1);
        Rst = 1'b1;
        #1;
        chk("rstmid_CS", CS, 1'b0);
        chk("rstmid_R_W", R_W, 1'b0);
        chk("rstmid_valid", resp_valid, 1'b0);
        @(posedge CLK); #2;
        Rst = 1'b0;
        repeat (3) begin
            @(posedge CLK); #2;
            chk("rstmid_no_resp", resp_valid, 1'b0);
        end
        chk("rstmid_ram9", ram[9], 32'h0BAD_F00D);
        do_req(1'b0, 2'd1, 1'b0, 14'h0024, 32'd0, 0, 1'b0, rd, er, lat, vc, cs_seen);
        chk("post_rst_lh", rd, 32'h0000_0BAD);
        chk("post_rst_lat", lat, 2);

        do_req(1'b1, 2'd2, 1'b0, 14'h3FFC, 32'hCAFE_F00D, 0, 1'b0, rd, er, lat, vc, cs_seen);
        do_req(1'b0, 2'd0, 1'b1, 14'h3FFD, 32'd0, 0, 1'b0, rd, er, lat, vc, cs_seen);
        chk("top_lbu", rd, 32'h0000_00FE);

        for (int n = 0; n < 300; n++) begin
            wsel = ($urandom_range(0, 7) == 0) ? AW'(NW - 1)
                                               : AW'($urandom_range(0, 15));
            ra   = {wsel, 2'($urandom_range(0, 3))};
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ra, $urandom,
                   $urandom_range(0, 2), 1'b1, rd, er, lat, vc, cs_seen);
        end

        repeat (3) @(posedge CLK);
        #2;
        for (int i = 0; i < NW; i++) chk("ram_final", ram[i], mram[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
